sbp_stage_mem_arbiter: RTL and testbench
========================================

# sbp_stage_mem_arbiter

Shares port A of one lookup-stage BRAM (`bram_tdp`) between the `sbp_lookup_stage` read path and a host table-update/read-back interface. Lookup reads have strict, non-stallable priority; host writes and read-backs are granted only in cycles with no lookup read. Read-back data returns through a registered response channel. Starvation is flagged when the host waits too long. The block sits between each `sbp_lookup_stage` instance and its stage RAM, replacing the direct stage-to-RAM connection.

## Interface
- `ADDR_BITS`, 11: stage RAM address width.
- `DATA_BITS`, 64: stage RAM data width.
- `WAIT_BITS`, 8: width of the host wait counter.
- `MAX_WAIT`, 255: wait-cycle count at which `starved_o` asserts; must be ≤ 2^WAIT_BITS − 1.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-low reset.
- `lk_read_i`  in  1  lookup stage read strobe.
- `lk_addr_i`  in  ADDR_BITS  lookup stage read address.
- `lk_data_o`  out  DATA_BITS  read data returned to the lookup stage.
- `host_valid_i`  in  1  host request valid.
- `host_ready_o`  out  1  host request accepted this cycle.
- `host_write_i`  in  1  1 = write, 0 = read-back.
- `host_addr_i`  in  ADDR_BITS  host address.
- `host_wdata_i`  in  DATA_BITS  host write data.
- `host_rvalid_o`  out  1  read-back data valid (one-cycle pulse).
- `host_rdata_o`  out  DATA_BITS  read-back data.
- `starved_o`  out  1  host request has waited `MAX_WAIT` cycles.
- `mem_wr_o`  out  1  RAM port A write enable.
- `mem_addr_o`  out  ADDR_BITS  RAM port A address.
- `mem_din_o`  out  DATA_BITS  RAM port A write data.
- `mem_dout_i`  in  DATA_BITS  RAM port A read data (1-cycle latency).

## Operation
- **Port mux (combinational)**
  - If `lk_read_i`: `mem_addr_o`=`lk_addr_i`, `mem_wr_o`=0.
  - Else if a host request is accepted: `mem_addr_o`=`host_addr_i`, `mem_wr_o`=`host_write_i`.
  - Otherwise: `mem_addr_o`=`lk_addr_i`, `mem_wr_o`=0.
  - `mem_din_o`=`host_wdata_i` always.
  - `lk_data_o`=`mem_dout_i` passthrough, so lookup latency is unchanged.
- **Host state machine**
  - IDLE: `host_ready_o` = !`lk_read_i`.
    - Accept = `host_valid_i` & `host_ready_o`.
    - Accepted write: the RAM write is issued that cycle; stay in IDLE.
    - Accepted read: the RAM read is issued; go to RD_WAIT.
  - RD_WAIT: `host_ready_o`=0.
    - Capture `mem_dout_i` into `host_rdata_o`.
    - Go to RD_RESP.
  - RD_RESP: `host_ready_o`=0.
    - `host_rvalid_o`=1 for exactly this cycle.
    - Go to IDLE.
- **Host protocol**
  - The host holds `host_valid_i`, `host_write_i`, `host_addr_i` and `host_wdata_i` stable until accepted.
  - `host_valid_i` never drops before acceptance.
- **Wait counter**
  - Increments each cycle `host_valid_i` & !accept; saturates at `MAX_WAIT`.
  - Clears to 0 on accept.
  - `starved_o` = (count == `MAX_WAIT`), registered. It stays high until the accept cycle, then clears the next cycle.
- **Simultaneous lookup read and host request**: the lookup wins, the host waits, and the counter increments.
- `host_rdata_o` holds its value until the next read-back capture.

## Timing
- **Reset values**: state IDLE; `host_rvalid_o`=0; `host_rdata_o`=0; `starved_o`=0; wait counter 0.
  - Combinational outputs follow their inputs during reset, with `host_ready_o`=0 and `mem_wr_o`=0 forced while `rst` is low.
- **Host write**: the RAM is written at the rising edge ending the accept cycle N. A lookup read of the same address in cycle N+1 returns the new data in N+2.
- **Host read-back**: accept at cycle N; `host_rvalid_o` high in cycle N+2. The earliest next accept is cycle N+3.
- **Host throughput**
  - Writes: up to one per cycle.
  - Reads: one per 3 cycles.
- **Lookup read**: address in cycle N, `lk_data_o` valid in N+1, never blocked.
- **Reset mid-read** (in RD_WAIT or RD_RESP): return to IDLE; no `host_rvalid_o` pulse is produced.

## Test plan
- **Reset**: `rst`=0 mid-traffic → all registered outputs 0, `host_ready_o`=0, `mem_wr_o`=0; after release, state IDLE.
- **Idle write, then read-back**
  - Write addr 0x005 data 0x0123456789ABCDEF with `lk_read_i`=0 → `host_ready_o`=1, `mem_wr_o`=1 that cycle.
  - Read-back of 0x005 → `host_rvalid_o` 2 cycles later with data 0x0123456789ABCDEF.
- **Collision**
  - Host write valid while `lk_read_i`=1 for 3 cycles → `host_ready_o`=0, `mem_wr_o`=0 and `mem_addr_o`=`lk_addr_i` for those 3 cycles.
  - Write accepted in cycle 4.
- **Lookup passthrough**: lookup reads addr 0x7FF then 0x000 back to back → `lk_data_o` matches preloaded RAM contents one cycle after each address.
- **Starvation** (`MAX_WAIT`=4)
  - `lk_read_i` held high with host valid → `starved_o` rises after 4 wait cycles.
  - Drop `lk_read_i` → accept occurs and `starved_o` clears the next cycle.
- **Reset mid-read-back**: assert `rst` in the RD_WAIT cycle → no `host_rvalid_o` pulse; next write accepted normally.

Source files
------------

// File: rtl/sbp_stage_mem_arbiter.sv
// Port-A arbiter for a lookup-stage BRAM: lookup reads always win,
// host writes/read-backs use idle cycles, with starvation flagging.
module sbp_stage_mem_arbiter #(
    parameter int ADDR_BITS = 11,
    parameter int DATA_BITS = 64,
    parameter int WAIT_BITS = 8,
    parameter int MAX_WAIT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lk_read_i,
    input  logic [ADDR_BITS-1:0] lk_addr_i,
    output logic [DATA_BITS-1:0] lk_data_o,
    input  logic                 host_valid_i,
    output logic                 host_ready_o,
    input  logic                 host_write_i,
    input  logic [ADDR_BITS-1:0] host_addr_i,
    input  logic [DATA_BITS-1:0] host_wdata_i,
    output logic                 host_rvalid_o,
    output logic [DATA_BITS-1:0] host_rdata_o,
    output logic                 starved_o,
    output logic                 mem_wr_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [DATA_BITS-1:0] mem_din_o,
    input  logic [DATA_BITS-1:0] mem_dout_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } state_t;

    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(MAX_WAIT);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic [WAIT_BITS-1:0] wait_nxt;

    // Ready is gated by reset so nothing reaches the RAM while rst is low.
    assign host_ready_o = rst && (state == IDLE) && !lk_read_i;
    assign accept       = host_valid_i && host_ready_o;

    assign mem_wr_o   = accept && host_write_i;
    assign mem_addr_o = accept ? host_addr_i : lk_addr_i;
    assign mem_din_o  = host_wdata_i;
    assign lk_data_o  = mem_dout_i;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && !host_write_i) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: state_nxt = RD_RESP;
            RD_RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (accept) begin
            wait_nxt = '0;
        end else if (host_valid_i && (wait_cnt != WAIT_MAX)) begin
            wait_nxt = wait_cnt + WAIT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            starved_o     <= 1'b0;
            host_rvalid_o <= 1'b0;
            host_rdata_o  <= '0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_nxt;
            starved_o     <= (wait_nxt == WAIT_MAX);
            host_rvalid_o <= (state == RD_WAIT);
            if (state == RD_WAIT) begin
                host_rdata_o <= mem_dout_i;
            end
        end
    end

endmodule

// File: tb/tb_sbp_stage_mem_arbiter.sv
// Bench for sbp_stage_mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model with its own RAM.
module tb_sbp_stage_mem_arbiter;

    localparam int AB = 11;
    localparam int DB = 64;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          lk_read = 1'b0;
    logic [AB-1:0] lk_addr = '0;
    logic [DB-1:0] lk_data;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic          host_write = 1'b0;
    logic [AB-1:0] host_addr = '0;
    logic [DB-1:0] host_wdata = '0;
    logic          host_rvalid;
    logic [DB-1:0] host_rdata;
    logic          starved;
    logic          mem_wr;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_din;
    logic [DB-1:0] mem_dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DB-1:0] ram [0:2047];
    logic [DB-1:0] model_mem [0:2047];

    sbp_stage_mem_arbiter #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB),
        .WAIT_BITS(8),
        .MAX_WAIT (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lk_read_i    (lk_read),
        .lk_addr_i    (lk_addr),
        .lk_data_o    (lk_data),
        .host_valid_i (host_valid),
        .host_ready_o (host_ready),
        .host_write_i (host_write),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_rvalid_o(host_rvalid),
        .host_rdata_o (host_rdata),
        .starved_o    (starved),
        .mem_wr_o     (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_din_o    (mem_din),
        .mem_dout_i   (mem_dout)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM standing in for bram_tdp port A.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
        lk_read    = 1'b0;
        host_valid = 1'b1;
        host_write = 1'b1;
        host_addr  = a;
        host_wdata = d;
        model_mem[a] = d;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [DB-1:0] d;
        d = 64'hA5A5_0000_1234_5678;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        do_write(11'h010, d);
        host_valid = 1'b1;
        host_write = 1'b0;
        host_addr  = 11'h010;
        tick();
        host_valid = 1'b0;
        tick();
        #2;
        n_tests++;
        if (host_rvalid !== 1'b1 || host_rdata !== d) begin
            n_fail++;
            $display("FAIL reset_pre_read rvalid=%b data=%h exp 1 %h",
                     host_rvalid, host_rdata, d);
        end
        tick();
        lk_read    = 1'b1;
        lk_addr    = 11'h001;
        host_valid = 1'b1;
        host_write = 1'b1;
        host_addr  = 11'h011;
        host_wdata = 64'h0F0F;
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (host_ready !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb ready=%b wr=%b exp 0 0",
                     host_ready, mem_wr);
        end
        n_tests++;
        if (host_rvalid !== 1'b0 || host_rdata !== '0 || starved !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs rvalid=%b rdata=%h starved=%b exp 0",
                     host_rvalid, host_rdata, starved);
        end
        lk_read = 1'b0;
        #1;
        n_tests++;
        if (host_ready !== 1'b0 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_forced ready=%b wr=%b exp 0 0",
                     host_ready, mem_wr);
        end
        tick();
        tick();
        rst = 1'b1;
        model_mem[11'h011] = 64'h0F0F;
        #2;
        n_tests++;
        if (host_ready !== 1'b1 || mem_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_idle ready=%b wr=%b exp 1 1",
                     host_ready, mem_wr);
        end
        tick();
        host_valid = 1'b0;
    endtask

    task automatic test_write_readback();
        logic [DB-1:0] d;
        d = 64'h0123_4567_89AB_CDEF;
        lk_read    = 1'b0;
        host_valid = 1'b1;
        host_write = 1'b1;
        host_addr  = 11'h005;
        host_wdata = d;
        #2;
        n_tests++;
        if (host_ready !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 11'h005) begin
            n_fail++;
            $display("FAIL wr_accept ready=%b wr=%b addr=%h exp 1 1 005",
                     host_ready, mem_wr, mem_addr);
        end
        model_mem[11'h005] = d;
        tick();
        host_write = 1'b0;
        host_wdata = '0;
        #2;
        n_tests++;
        if (host_ready !== 1'b1 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_accept ready=%b wr=%b exp 1 0",
                     host_ready, mem_wr);
        end
        tick();
        host_valid = 1'b0;
        #2;
        n_tests++;
        if (host_rvalid !== 1'b0 || host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait rvalid=%b ready=%b exp 0 0",
                     host_rvalid, host_ready);
        end
        tick();
        #2;
        n_tests++;
        if (host_rvalid !== 1'b1 || host_rdata !== d) begin
            n_fail++;
            $display("FAIL rd_resp rvalid=%b data=%h exp 1 %h",
                     host_rvalid, host_rdata, d);
        end
        tick();
        #2;
        n_tests++;
        if (host_rvalid !== 1'b0 || host_rdata !== d) begin
            n_fail++;
            $display("FAIL rd_hold rvalid=%b data=%h exp 0 %h",
                     host_rvalid, host_rdata, d);
        end
    endtask

    task automatic test_collision();
        logic [DB-1:0] d;
        d = 64'hDEAD_BEEF_CAFE_F00D;
        lk_read    = 1'b1;
        lk_addr    = 11'h123;
        host_valid = 1'b1;
        host_write = 1'b1;
        host_addr  = 11'h040;
        host_wdata = d;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_tests++;
            if (host_ready !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 11'h123) begin
                n_fail++;
                $display("FAIL collide_%0d ready=%b wr=%b addr=%h exp 0 0 123",
                         i, host_ready, mem_wr, mem_addr);
            end
            tick();
        end
        lk_read = 1'b0;
        #2;
        n_tests++;
        if (host_ready !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 11'h040) begin
            n_fail++;
            $display("FAIL collide_accept ready=%b wr=%b addr=%h exp 1 1 040",
                     host_ready, mem_wr, mem_addr);
        end
        model_mem[11'h040] = d;
        tick();
        host_valid = 1'b0;
        lk_read    = 1'b1;
        lk_addr    = 11'h040;
        tick();
        lk_read = 1'b0;
        #2;
        n_tests++;
        if (lk_data !== d || starved !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_data data=%h starved=%b exp %h 0",
                     lk_data, starved, d);
        end
    endtask

    task automatic test_passthrough();
        logic [DB-1:0] a;
        logic [DB-1:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        do_write(11'h7FF, a);
        do_write(11'h000, b);
        lk_read = 1'b1;
        lk_addr = 11'h7FF;
        tick();
        lk_addr = 11'h000;
        #2;
        n_tests++;
        if (lk_data !== a) begin
            n_fail++;
            $display("FAIL lk_7ff data=%h exp %h", lk_data, a);
        end
        tick();
        lk_read = 1'b0;
        #2;
        n_tests++;
        if (lk_data !== b) begin
            n_fail++;
            $display("FAIL lk_000 data=%h exp %h", lk_data, b);
        end
    endtask

    task automatic test_starvation();
        lk_read    = 1'b1;
        lk_addr    = 11'h002;
        host_valid = 1'b1;
        host_write = 1'b1;
        host_addr  = 11'h0AA;
        host_wdata = 64'h5555;
        #2;
        n_tests++;
        if (starved !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_0 starved=%b exp 0", starved);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            #2;
            n_tests++;
            if (starved !== (i >= MW)) begin
                n_fail++;
                $display("FAIL starve_%0d starved=%b exp %b",
                         i, starved, (i >= MW));
            end
        end
        lk_read = 1'b0;
        #1;
        n_tests++;
        if (host_ready !== 1'b1 || starved !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_accept ready=%b starved=%b exp 1 1",
                     host_ready, starved);
        end
        model_mem[11'h0AA] = 64'h5555;
        tick();
        host_valid = 1'b0;
        #2;
        n_tests++;
        if (starved !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_clear starved=%b exp 0", starved);
        end
    endtask

    task automatic test_reset_midread();
        do_write(11'h033, 64'h3333_3333);
        host_valid = 1'b1;
        host_write = 1'b0;
        host_addr  = 11'h033;
        tick();
        host_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (host_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_rst rvalid=%b exp 0", host_rvalid);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_tests++;
            if (host_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL midread_pulse_%0d rvalid=%b exp 0",
                         i, host_rvalid);
            end
            tick();
        end
        host_valid = 1'b1;
        host_write = 1'b1;
        host_addr  = 11'h034;
        host_wdata = 64'h3434;
        #2;
        n_tests++;
        if (host_ready !== 1'b1 || mem_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_next_wr ready=%b wr=%b exp 1 1",
                     host_ready, mem_wr);
        end
        model_mem[11'h034] = 64'h3434;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic test_random();
        logic          pend;
        logic          pw;
        logic [AB-1:0] pa;
        logic [DB-1:0] pd;
        logic          lk;
        logic [AB-1:0] la;
        logic          lk_prev;
        logic [DB-1:0] lk_exp;
        logic [DB-1:0] rd_exp;
        logic          exp_starved;
        logic          exp_acc;
        int            busy;
        int            waits;
        int            rd_due;
        int            errs;
        for (int k = 0; k < 16; k++) begin
            do_write(AB'(k), {$urandom, $urandom});
        end
        pend = 1'b0;
        pw = 1'b0;
        pa = '0;
        pd = '0;
        lk_prev = 1'b0;
        lk_exp = '0;
        rd_exp = '0;
        exp_starved = 1'b0;
        busy = 0;
        waits = 0;
        rd_due = -1;
        errs = 0;
        for (int c = 0; c < 500; c++) begin
            if (!pend && ($urandom % 3 == 0)) begin
                pend = 1'b1;
                pw = 1'($urandom % 2);
                pa = AB'($urandom % 16);
                pd = {$urandom, $urandom};
            end
            lk = 1'($urandom % 2);
            la = AB'($urandom % 16);
            lk_read    = lk;
            lk_addr    = la;
            host_valid = pend;
            host_write = pw;
            host_addr  = pa;
            host_wdata = pd;
            #2;
            exp_acc = pend && !lk && (busy == 0);
            n_tests++;
            if (host_ready !== (!lk && busy == 0) || mem_wr !== (exp_acc && pw)) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL rnd_ctl c=%0d ready=%b wr=%b exp %b %b",
                             c, host_ready, mem_wr, (!lk && busy == 0), (exp_acc && pw));
            end
            n_tests++;
            if (mem_addr !== (exp_acc ? pa : la)) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL rnd_addr c=%0d addr=%h exp %h",
                             c, mem_addr, (exp_acc ? pa : la));
            end
            n_tests++;
            if (host_rvalid !== (rd_due == c) || starved !== exp_starved) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL rnd_flags c=%0d rvalid=%b starved=%b exp %b %b",
                             c, host_rvalid, starved, (rd_due == c), exp_starved);
            end
            if (rd_due == c) begin
                n_tests++;
                if (host_rdata !== rd_exp) begin
                    n_fail++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL rnd_rdata c=%0d data=%h exp %h",
                                 c, host_rdata, rd_exp);
                end
            end
            if (lk_prev) begin
                n_tests++;
                if (lk_data !== lk_exp) begin
                    n_fail++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL rnd_lk c=%0d data=%h exp %h",
                                 c, lk_data, lk_exp);
                end
            end
            lk_prev = lk;
            if (lk) lk_exp = model_mem[la];
            if (busy > 0) busy--;
            if (exp_acc) begin
                if (pw) begin
                    model_mem[pa] = pd;
                end else begin
                    rd_exp = model_mem[pa];
                    rd_due = c + 2;
                    busy = 2;
                end
                pend = 1'b0;
                waits = 0;
            end else if (pend && waits < MW) begin
                waits++;
            end
            exp_starved = (waits == MW);
            tick();
        end
        host_valid = 1'b0;
        lk_read = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_collision();
        test_passthrough();
        test_starvation();
        test_reset_midread();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
